main_control_fsm: RTL
=====================

# main_control_fsm

Multi-cycle main control unit for the LEGv8 datapath. It consumes the opcode field held in the instruction register and sequences FETCH/DECODE/EXECUTE/MEM/WRITEBACK. It drives every datapath enable plus the 2-bit ALUOp (ALUOp1, ALUOp0) consumed by the ALU control decoder. It also keeps a retired-instruction counter and flags unsupported opcodes.

## Interface
- COUNT_WIDTH, 32, width of retired-instruction counter
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- opcode  input  11  IR[31:21], stable from DECODE until return to FETCH
- mem_ready  input  1  memory completes the requested access this cycle
- ALUOp1, ALUOp0  output  1 each  to ALU control: 00 add, 01 pass-B (CBZ), 10 R-type field decode
- ALUSrcA  output  1  0=PC, 1=register A
- ALUSrcB  output  2  00=reg B, 01=constant 4, 10=sign-ext imm, 11=sign-ext imm<<2
- IorD  output  1  0=PC address, 1=ALUOut address
- MemRead, MemWrite, IRWrite, RegWrite, MemtoReg, PCWrite, PCWriteCond, Reg2Loc  output  1 each  datapath controls
- PCSource  output  1  0=ALU result, 1=ALUOut (branch target)
- illegal  output  1  unsupported opcode trapped
- retired  output  COUNT_WIDTH  completed-instruction count
- state  output  4  current state encoding (debug)

## Operation
- Decode classes: ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000 (R-type); LDUR 11111000010; STUR 11111000000; CBZ opcode[10:3]=10110100; B opcode[10:5]=000101. Any other opcode is illegal.
- States and encodings:
  - FETCH(0): MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=0. IRWrite=PCWrite=mem_ready. Hold while mem_ready=0; on mem_ready go to DECODE.
  - DECODE(1): ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target into ALUOut). Next state: R-type goes to EXECUTE, LDUR/STUR to MEM_ADDR, CBZ to BRANCH, B to JUMP, other opcodes to TRAP.
  - MEM_ADDR(2): ALUSrcA=1, ALUSrcB=10, ALUOp=00. LDUR goes to MEM_READ; STUR goes to MEM_WRITE.
  - MEM_READ(3): MemRead=1, IorD=1. Hold until mem_ready, then MEM_WB.
  - MEM_WB(4): RegWrite=1, MemtoReg=1. Next state FETCH.
  - MEM_WRITE(5): MemWrite=1, IorD=1. Hold until mem_ready, then FETCH.
  - EXECUTE(6): ALUSrcA=1, ALUSrcB=00, ALUOp=10. Next state R_WB.
  - R_WB(7): RegWrite=1, MemtoReg=0. Next state FETCH.
  - BRANCH(8): ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=1. Next state FETCH.
  - JUMP(9): PCWrite=1, PCSource=1. Next state FETCH.
  - TRAP(10): all enables 0, illegal=1. Stays in TRAP until reset.
- Reg2Loc=1 in DECODE, MEM_ADDR, MEM_WRITE and BRANCH when opcode is STUR or CBZ; 0 otherwise.
- Any output not listed for a state is 0. ALUOp is 00 in states that do not specify it.
- retired increments by 1 on every transition into FETCH from MEM_WB, MEM_WRITE, R_WB, BRANCH or JUMP. It wraps from 2^COUNT_WIDTH-1 to 0.
- Unused encodings 11-15 go to TRAP on the next edge.

## Timing
- state, retired and illegal are registered. All control outputs are combinational from state and opcode. IRWrite and PCWrite in FETCH also depend on mem_ready (Mealy).
- Reset: rst_n=0 at a rising edge sets state=FETCH, retired=0, illegal=0.
- While rst_n=0, MemRead, MemWrite, IRWrite, RegWrite, PCWrite and PCWriteCond are forced to 0. This applies even mid-instruction; a reset during MEM_WRITE aborts the store with no write.
- Cycles per instruction with mem_ready always 1: R-type 4, LDUR 5, STUR 4, CBZ 3, B 3.
- Each cycle that mem_ready=0 in FETCH, MEM_READ or MEM_WRITE adds one cycle. Outputs hold steady during the stall.
- mem_ready is ignored in all other states.

## Test plan
- Reset, then ADD (10001011000) with mem_ready=1: states 0→1→6→7→0. ALUOp=10 only in state 6, RegWrite=1 only in state 7, retired=1.
- LDUR with mem_ready low for 2 cycles in MEM_READ: 0→1→2→3→3→3→4→0 (7 cycles). MemRead and IorD=1 held through all three cycles of state 3. MemtoReg=1 in state 4.
- STUR then CBZ: Reg2Loc=1 in states 1, 2, 5 (STUR) and 1, 8 (CBZ). In state 8, ALUOp=01 and PCWriteCond=1. retired goes 0→2.
- Opcode 11111111111: DECODE→TRAP, illegal=1, all enables 0 for 10+ cycles. rst_n=0 then returns state=0 with illegal=0.
- Preload retired=2^COUNT_WIDTH-1 (force or COUNT_WIDTH=4 with 15 instructions), retire one B: retired=0.
- Assert rst_n=0 in MEM_WRITE: MemWrite=0 that cycle, next state=0, retired=0.

Source files
------------

// File: rtl/main_control_fsm.sv
// LEGv8 multi-cycle main control: sequences fetch/decode/execute,
// drives datapath enables, counts retired instructions, traps bad opcodes.
module main_control_fsm #(
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [10:0]            opcode,
  input  logic                   mem_ready,
  output logic                   ALUOp1,
  output logic                   ALUOp0,
  output logic                   ALUSrcA,
  output logic [1:0]             ALUSrcB,
  output logic                   IorD,
  output logic                   MemRead,
  output logic                   MemWrite,
  output logic                   IRWrite,
  output logic                   RegWrite,
  output logic                   MemtoReg,
  output logic                   PCWrite,
  output logic                   PCWriteCond,
  output logic                   Reg2Loc,
  output logic                   PCSource,
  output logic                   illegal,
  output logic [COUNT_WIDTH-1:0] retired,
  output logic [3:0]             state
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXECUTE   = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_TRAP      = 4'd10
  } state_e;

  state_e                 state_q, state_d;
  logic [COUNT_WIDTH-1:0] retired_q;
  logic                   illegal_q;
  logic                   retire;

  logic is_r, is_ld, is_st, is_cbz, is_b;

  assign is_r   = (opcode == 11'b10001011000)
               || (opcode == 11'b11001011000)
               || (opcode == 11'b10001010000)
               || (opcode == 11'b10101010000);
  assign is_ld  = (opcode == 11'b11111000010);
  assign is_st  = (opcode == 11'b11111000000);
  assign is_cbz = (opcode[10:3] == 8'b10110100);
  assign is_b   = (opcode[10:5] == 6'b000101);

  always_comb begin
    state_d     = state_q;
    ALUOp1      = 1'b0;
    ALUOp0      = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    RegWrite    = 1'b0;
    MemtoReg    = 1'b0;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    PCSource    = 1'b0;
    Reg2Loc     = 1'b0;
    case (state_q)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        Reg2Loc = is_st | is_cbz;
        unique case (1'b1)
          is_r:          state_d = S_EXECUTE;
          is_ld | is_st: state_d = S_MEM_ADDR;
          is_cbz:        state_d = S_BRANCH;
          is_b:          state_d = S_JUMP;
          default:       state_d = S_TRAP;
        endcase
      end
      S_MEM_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        Reg2Loc = is_st | is_cbz;
        if (is_ld)      state_d = S_MEM_READ;
        else if (is_st) state_d = S_MEM_WRITE;
        else            state_d = S_TRAP;
      end
      S_MEM_READ: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        if (mem_ready) state_d = S_MEM_WB;
      end
      S_MEM_WB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
        state_d  = S_FETCH;
      end
      S_MEM_WRITE: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        Reg2Loc  = is_st | is_cbz;
        if (mem_ready) state_d = S_FETCH;
      end
      S_EXECUTE: begin
        ALUSrcA = 1'b1;
        ALUOp1  = 1'b1;
        state_d = S_R_WB;
      end
      S_R_WB: begin
        RegWrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp0      = 1'b1;
        PCWriteCond = 1'b1;
        PCSource    = 1'b1;
        Reg2Loc     = is_st | is_cbz;
        state_d     = S_FETCH;
      end
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 1'b1;
        state_d  = S_FETCH;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_TRAP;
    endcase
    // Reset must abort any in-flight memory or register write.
    if (!rst_n) begin
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      RegWrite    = 1'b0;
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
    end
  end

  assign retire = (state_d == S_FETCH)
               && ((state_q == S_MEM_WB)
               ||  (state_q == S_MEM_WRITE)
               ||  (state_q == S_R_WB)
               ||  (state_q == S_BRANCH)
               ||  (state_q == S_JUMP));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      retired_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= (state_d == S_TRAP);
      if (retire) retired_q <= retired_q + COUNT_WIDTH'(1);
    end
  end

  assign state   = state_q;
  assign retired = retired_q;
  assign illegal = illegal_q;

endmodule
